tdm_ingress_mux16: RTL and testbench

Upstream feeder for the 16×16 dispatch/BPU core. It takes 16 independent byte-wide ingress port streams, each with a valid/ready handshake and a start-of-packet flag, and buffers each in a per-port FIFO. It time-division multiplexes them onto the core's single serial input (`input_wire`, `input_new_packet`, `input_data`). Its slot counter resets and advances in lock-step with the core's `input_sel`, so each cycle's output carries the byte for the port the core is currently sampling.

---
 rtl/tdm_pkg.sv | 30 +++
 rtl/tdm_port_fifo.sv | 104 ++++++++++
 rtl/tdm_ingress_mux16.sv | 120 ++++++++++++
 tb/tb_tdm_ingress_mux16.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared constants and types for the TDM ingress multiplexer that feeds the
// 16x16 dispatch core.
//   TDM_NUM_QUEUES : number of ingress ports / data-carrying slots
//   TDM_SLOT_BITS  : slot counter width (frame = 2**TDM_SLOT_BITS cycles)
//   TDM_DATA_WIDTH : byte width of each port and of the TDM output
//   tdm_entry_t    : one buffered FIFO entry, {sop, data}
// -----------------------------------------------------------------------------
package tdm_pkg;

    localparam int TDM_NUM_QUEUES = 16;
    localparam int TDM_SLOT_BITS  = 8;
    localparam int TDM_DATA_WIDTH = 8;

    typedef struct packed {
        logic                      sop;
        logic [TDM_DATA_WIDTH-1:0] data;
    } tdm_entry_t;

    // Packs a start-of-packet flag and a byte into one FIFO entry.
    function automatic tdm_entry_t tdm_pack(input logic                      sop,
                                            input logic [TDM_DATA_WIDTH-1:0] data);
        tdm_entry_t e;
        e.sop  = sop;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/tdm_port_fifo.sv
// -----------------------------------------------------------------------------
// tdm_port_fifo
// Synchronous FIFO of FIFO_DEPTH entries, each (DATA_WIDTH+1) bits wide
// ({sop, data}). Push is ignored while full, pop is ignored while empty.
// A push and a pop in the same cycle are both honoured. The head entry is
// presented combinationally on rd_data_o; there is no write-to-read bypass.
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset (flushes the FIFO)
//   push_i     : write request
//   wr_data_i  : entry to write
//   pop_i      : read request (removes the head)
//   rd_data_o  : current head entry
//   full_o     : count == FIFO_DEPTH
//   empty_o    : count == 0
//   count_o    : number of stored entries
// -----------------------------------------------------------------------------
module tdm_port_fifo
    import tdm_pkg::*;
#(
    parameter int DATA_WIDTH = TDM_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = $clog2(FIFO_DEPTH),
    parameter int CNT_W      = PTR_W + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH:0]   wr_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH:0]   rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o
);

    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                do_push_s;
    logic                do_pop_s;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == CNT_ZERO);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i  & ~empty_o;

    // Next-state for pointers and occupancy count; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; cleared on reset so no stale entry can ever be observed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {(DATA_WIDTH+1){1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/tdm_ingress_mux16.sv
// -----------------------------------------------------------------------------
// tdm_ingress_mux16
// Buffers 16 byte-wide ingress streams in per-port FIFOs and time-division
// multiplexes them onto the dispatch core's serial input. The slot counter
// runs free from reset in lock-step with the core's input_sel; on the edge
// that enters slot s (s < NUM_QUEUES) the head of FIFO s is popped into the
// output registers, so the output carries port s data exactly while slot==s.
// Ports:
//   clk              : clock, rising edge
//   rst              : asynchronous active-low reset
//   in_valid         : per-port byte valid
//   in_sop           : per-port start-of-packet, qualified by in_valid
//   in_data          : port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   in_ready         : per-port FIFO not full
//   input_wire       : TDM byte valid to the core
//   input_new_packet : TDM start-of-packet to the core
//   input_data       : TDM byte to the core
//   slot             : current slot, equal to the core's input_sel
//   fifo_full        : per-port full status (~in_ready)
// -----------------------------------------------------------------------------
module tdm_ingress_mux16
    import tdm_pkg::*;
#(
    parameter int DATA_WIDTH = TDM_DATA_WIDTH,
    parameter int NUM_QUEUES = TDM_NUM_QUEUES,
    parameter int SLOT_BITS  = TDM_SLOT_BITS,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_QUEUES-1:0]          in_valid,
    input  logic [NUM_QUEUES-1:0]          in_sop,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    output logic [NUM_QUEUES-1:0]          in_ready,
    output logic                           input_wire,
    output logic                           input_new_packet,
    output logic [DATA_WIDTH-1:0]          input_data,
    output logic [SLOT_BITS-1:0]           slot,
    output logic [NUM_QUEUES-1:0]          fifo_full
);

    localparam int ENTRY_W = DATA_WIDTH + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [SLOT_BITS-1:0] SLOT_ONE   = {{(SLOT_BITS-1){1'b0}}, 1'b1};
    localparam logic [ENTRY_W-1:0]   ENTRY_ZERO = {ENTRY_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_FULL   = CNT_W'(FIFO_DEPTH);

    logic [SLOT_BITS-1:0]  slot_q, slot_d;
    logic [NUM_QUEUES-1:0] full_s;
    logic [NUM_QUEUES-1:0] empty_s;
    logic [NUM_QUEUES-1:0] pop_s;
    logic [ENTRY_W-1:0]    head_s  [NUM_QUEUES];
    logic [CNT_W-1:0]      count_s [NUM_QUEUES];
    logic [ENTRY_W-1:0]    sel_s;
    tdm_entry_t            out_q, out_d;
    logic                  wire_q, wire_d;

    // The slot counter never stalls; wrap at 2**SLOT_BITS is implicit.
    assign slot_d = slot_q + SLOT_ONE;

    genvar q;
    generate
        for (q = 0; q < NUM_QUEUES; q++) begin : g_port
            tdm_port_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk_i     (clk),
                .rst_ni    (rst),
                .push_i    (in_valid[q]),
                .wr_data_i (tdm_pack(in_sop[q], in_data[q*DATA_WIDTH +: DATA_WIDTH])),
                .pop_i     (pop_s[q]),
                .rd_data_o (head_s[q]),
                .full_o    (full_s[q]),
                .empty_o   (empty_s[q]),
                .count_o   (count_s[q])
            );

            assign in_ready[q] = (count_s[q] != CNT_FULL);

            // Pop on the edge that enters this port's slot, decoded from the
            // next slot value so the output register lines up with slot.
            assign pop_s[q] = (slot_d == SLOT_BITS'(q)) & ~empty_s[q];
        end
    endgenerate

    assign fifo_full = full_s;

    // One-hot select of the popped head; all-zero when no pop (empty FIFO or
    // slot beyond the data-carrying range).
    always_comb begin
        sel_s = ENTRY_ZERO;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            sel_s = sel_s | (pop_s[i] ? head_s[i] : ENTRY_ZERO);
        end
        out_d  = sel_s;
        wire_d = |pop_s;
    end

    // Slot counter and TDM output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= {SLOT_BITS{1'b0}};
            out_q  <= ENTRY_ZERO;
            wire_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            out_q  <= out_d;
            wire_q <= wire_d;
        end
    end

    assign slot             = slot_q;
    assign input_wire       = wire_q;
    assign input_new_packet = out_q.sop;
    assign input_data       = out_q.data;

endmodule

// File: tb/tb_tdm_ingress_mux16.sv
module tb_tdm_ingress_mux16;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  in_valid;
    logic [15:0]  in_sop;
    logic [127:0] in_data;
    logic [15:0]  in_ready;
    logic         input_wire;
    logic         input_new_packet;
    logic [7:0]   input_data;
    logic [7:0]   slot;
    logic [15:0]  fifo_full;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdm_ingress_mux16 dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_sop           (in_sop),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .input_wire       (input_wire),
        .input_new_packet (input_new_packet),
        .input_data       (input_data),
        .slot             (slot),
        .fifo_full        (fifo_full)
    );

    typedef struct {
        int         port;
        logic       sop;
        logic [7:0] data;
        int         push_slot;
        int         exp_delay;   // observations after the push edge until it shows
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps at least once, then until slot reaches target (bounded).
    task automatic wait_slot(input int target, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (slot != 8'(target) && n < 300);
        check(tag, 32'(slot), 32'(target));
    endtask

    task automatic clear_inputs();
        in_valid = 16'h0000;
        in_sop   = 16'h0000;
        in_data  = 128'h0;
    endtask

    task automatic drive(input int p, input logic s, input logic [7:0] d);
        in_valid[p]       = 1'b1;
        in_sop[p]         = s;
        in_data[p*8 +: 8] = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int hits;
        vecs[0] = '{port: 3,  sop: 1'b1, data: 8'hA5, push_slot: 10,  exp_delay: 248};
        vecs[1] = '{port: 7,  sop: 1'b0, data: 8'h3C, push_slot: 6,   exp_delay: 256};
        vecs[2] = '{port: 15, sop: 1'b1, data: 8'hFF, push_slot: 200, exp_delay: 70};
        vecs[3] = '{port: 0,  sop: 1'b1, data: 8'h01, push_slot: 255, exp_delay: 256};
        vecs[4] = '{port: 12, sop: 1'b0, data: 8'h80, push_slot: 12,  exp_delay: 255};

        rst = 1'b0;
        clear_inputs();
        step(); step(); step();
        check("rst_slot",  32'(slot), 32'd0);
        check("rst_ready", 32'(in_ready), 32'h0000FFFF);
        check("rst_full",  32'(fifo_full), 32'd0);
        check("rst_wire",  32'(input_wire), 32'd0);
        check("rst_sop",   32'(input_new_packet), 32'd0);
        check("rst_data",  32'(input_data), 32'd0);

        // Idle frame: counter sequence, ready and idle output.
        rst = 1'b1;
        for (int n = 0; n <= 256; n++) begin
            if (n > 0) step();
            check("idle_slot",  32'(slot), 32'(n % 256));
            check("idle_ready", 32'(in_ready), 32'h0000FFFF);
            check("idle_wire",  32'(input_wire), 32'd0);
            check("idle_full",  32'(fifo_full), 32'd0);
        end

        // Table-driven single-byte latency vectors.
        for (int v = 0; v < 5; v++) begin
            wait_slot(vecs[v].push_slot, "vec_wait");
            drive(vecs[v].port, vecs[v].sop, vecs[v].data);
            step();
            clear_inputs();
            hits = 0;
            for (int n = 0; n <= 260; n++) begin
                if (n > 0) step();
                if (input_wire || input_new_packet || input_data != 8'h00) hits++;
                if (n == vecs[v].exp_delay) begin
                    check("vec_slot", 32'(slot), 32'(vecs[v].port));
                    check("vec_wire", 32'(input_wire), 32'd1);
                    check("vec_sop",  32'(input_new_packet), 32'(vecs[v].sop));
                    check("vec_data", 32'(input_data), 32'(vecs[v].data));
                end
            end
            check("vec_hits", 32'(hits), 32'd1);
        end

        // Port 0: fill to full, then drain one byte per frame.
        wait_slot(1, "p0_wait");
        for (int i = 0; i < 16; i++) begin
            check("p0_ready_fill", 32'(in_ready[0]), 32'd1);
            drive(0, (i == 0), 8'(8'h40 + i));
            step();
        end
        clear_inputs();
        check("p0_ready_full", 32'(in_ready[0]), 32'd0);
        check("p0_fifo_full",  32'(fifo_full[0]), 32'd1);
        wait_slot(255, "p0_wait255");
        check("p0_ready_prepop", 32'(in_ready[0]), 32'd0);
        step();
        check("p0_slot0",      32'(slot), 32'd0);
        check("p0_ready_rise", 32'(in_ready[0]), 32'd1);
        check("p0_wire0",      32'(input_wire), 32'd1);
        check("p0_sop0",       32'(input_new_packet), 32'd1);
        check("p0_data0",      32'(input_data), 32'h40);
        for (int i = 1; i < 16; i++) begin
            wait_slot(0, "p0_wait0");
            check("p0_wire", 32'(input_wire), 32'd1);
            check("p0_sop",  32'(input_new_packet), 32'd0);
            check("p0_data", 32'(input_data), 32'(8'h40 + i));
        end
        wait_slot(0, "p0_wait_end");
        check("p0_drained", 32'(input_wire), 32'd0);

        // Port 5: valid held high while full across the slot-5 pop edge.
        wait_slot(20, "p5_wait");
        for (int i = 0; i < 16; i++) begin
            drive(5, (i == 0), 8'(8'h50 + i));
            step();
        end
        drive(5, 1'b0, 8'h99);
        wait_slot(4, "p5_wait4");
        check("p5_ready_full", 32'(in_ready[5]), 32'd0);
        step();
        check("p5_ready_after_pop", 32'(in_ready[5]), 32'd1);
        check("p5_pop_data",        32'(input_data), 32'h50);
        check("p5_pop_sop",         32'(input_new_packet), 32'd1);
        step();
        check("p5_ready_refull", 32'(in_ready[5]), 32'd0);
        check("p5_full_refull",  32'(fifo_full[5]), 32'd1);
        clear_inputs();
        for (int i = 1; i < 16; i++) begin
            wait_slot(5, "p5_wait5");
            check("p5_data", 32'(input_data), 32'(8'h50 + i));
        end
        wait_slot(5, "p5_wait5b");
        check("p5_late_wire", 32'(input_wire), 32'd1);
        check("p5_late_data", 32'(input_data), 32'h99);
        wait_slot(5, "p5_wait5c");
        check("p5_drained", 32'(input_wire), 32'd0);

        // All ports push in one cycle; the next frame carries 0x10..0x1F.
        wait_slot(100, "all_wait");
        for (int p = 0; p < 16; p++) drive(p, p[0], 8'(8'h10 + p));
        step();
        clear_inputs();
        wait_slot(0, "all_wait0");
        for (int s = 0; s < 256; s++) begin
            if (s > 0) step();
            check("all_slot", 32'(slot), 32'(s));
            if (s < 16) begin
                check("all_wire", 32'(input_wire), 32'd1);
                check("all_sop",  32'(input_new_packet), 32'(s % 2));
                check("all_data", 32'(input_data), 32'(8'h10 + s));
            end else begin
                check("all_idle_wire", 32'(input_wire), 32'd0);
                check("all_idle_sop",  32'(input_new_packet), 32'd0);
                check("all_idle_data", 32'(input_data), 32'd0);
            end
        end

        // Reset mid-frame with data queued.
        wait_slot(50, "mr_wait");
        drive(2, 1'b1, 8'h77);
        drive(9, 1'b1, 8'h66);
        step();
        clear_inputs();
        drive(2, 1'b0, 8'h78);
        step();
        clear_inputs();
        wait_slot(2, "mr_wait2");
        check("mr_pre_data", 32'(input_data), 32'h77);
        rst = 1'b0;
        #2;
        check("mr_slot",  32'(slot), 32'd0);
        check("mr_wire",  32'(input_wire), 32'd0);
        check("mr_sop",   32'(input_new_packet), 32'd0);
        check("mr_data",  32'(input_data), 32'd0);
        check("mr_ready", 32'(in_ready), 32'h0000FFFF);
        check("mr_full",  32'(fifo_full), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        check("mr_rel_slot", 32'(slot), 32'd0);
        hits = 0;
        for (int n = 1; n <= 300; n++) begin
            step();
            if (input_wire || input_new_packet || input_data != 8'h00) hits++;
        end
        check("mr_no_stale", 32'(hits), 32'd0);
        check("mr_slot_run", 32'(slot), 32'(300 % 256));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
